// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, flag positions and
// the sequencer state type.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [4:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin finder: first set bit of vec_i at or after ptr_i,
// wrapping around to bit 0.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] cand;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (vec_i[cand[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external combinational ALU between NREQ
// requesters: accept one op, drive the ALU for one cycle, return the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*5-1:0]    req_op,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_result,
  output logic [3:0]           resp_flags,
  output logic                 resp_err,
  output logic [XLEN-1:0]      alu_srcA,
  output logic [XLEN-1:0]      alu_srcB,
  output logic [4:0]           alu_control,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 alu_carry,
  input  logic                 alu_overflow
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     grant_q;
  logic [XLEN-1:0]   src_a_q;
  logic [XLEN-1:0]   src_b_q;
  alu_op_e           ctrl_q;
  logic [XLEN-1:0]   result_q;
  logic [3:0]        flags_q;
  logic              err_q;
  logic [NREQ-1:0]   resp_valid_q;

  logic [XLEN-1:0]   a_arr  [NREQ];
  logic [XLEN-1:0]   b_arr  [NREQ];
  logic [4:0]        op_arr [NREQ];

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              accept;
  logic              pick_legal;
  logic              is_compare;
  logic [IW-1:0]     rr_ptr_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]  = req_a[i*XLEN +: XLEN];
      b_arr[i]  = req_b[i*XLEN +: XLEN];
      op_arr[i] = req_op[i*5 +: 5];
    end
  end

  rr_picker #(.N(NREQ), .IW(IW)) u_picker (
    .vec_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept     = (state_q == ST_IDLE) && pick_found;
  assign pick_legal = alu_op_legal(op_arr[pick_idx]);
  assign is_compare = (ctrl_q == ALU_SLT) || (ctrl_q == ALU_SLTU);
  assign rr_ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  // Grant is combinational so the accept handshake completes in the same
  // cycle the request is first seen in IDLE.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick_idx] = 1'b1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and clears the in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      ctrl_q       <= ALU_ADD;
      result_q     <= '0;
      flags_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_q <= pick_idx;
            if (pick_legal) begin
              src_a_q <= a_arr[pick_idx];
              src_b_q <= b_arr[pick_idx];
              ctrl_q  <= alu_op_e'(op_arr[pick_idx]);
              state_q <= ST_EXEC;
            end else begin
              // Illegal ops bypass the ALU and leave its inputs untouched.
              result_q     <= '0;
              flags_q      <= '0;
              err_q        <= 1'b1;
              resp_valid_q <= NREQ'(1) << pick_idx;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          result_q             <= alu_result;
          flags_q[FLAG_Z]      <= alu_zero;
          flags_q[FLAG_N]      <= alu_neg;
          flags_q[FLAG_C]      <= alu_carry && !is_compare;
          flags_q[FLAG_V]      <= alu_overflow && !is_compare;
          err_q                <= 1'b0;
          resp_valid_q         <= NREQ'(1) << grant_q;
          state_q              <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;
  assign alu_srcA    = src_a_q;
  assign alu_srcB    = src_b_q;
  assign alu_control = ctrl_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing one combinational RV32I ALU between `NREQ` requesters, for example the integer pipeline and an address/CSR helper unit. It accepts one operation at a time over a valid/ready request channel and drives the shared ALU from registered operands. It captures the result and flags and returns them on a per-requester valid/ready response channel. It sits between the requesters and the `alu` instance and owns all of that instance's inputs.

## Interface
- `XLEN`, 32: operand and result width.
- `NREQ`, 2: number of requesters, 2..8; `IW = $clog2(NREQ)`.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NREQ: per-requester operation valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_a`, `req_b`  in  NREQ×XLEN: packed operands, requester i at `[i*XLEN +: XLEN]`.
- `req_op`  in  NREQ×5: packed `alu_op_e` codes.
- `resp_valid`  out  NREQ: per-requester result valid; one-hot or zero.
- `resp_ready`  in  NREQ: per-requester result consume.
- `resp_result`  out  XLEN: result, shared by all requesters and qualified by `resp_valid`.
- `resp_flags`  out  4: {V,C,N,Z}.
- `resp_err`  out  1: illegal opcode.
- `alu_srcA`, `alu_srcB`  out  XLEN: operands to the shared ALU.
- `alu_control`  out  5: opcode to the shared ALU.
- `alu_result`  in  XLEN: result from the shared ALU.
- `alu_zero`, `alu_neg`, `alu_carry`, `alu_overflow`  in  1: flags from the shared ALU.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - When any `req_valid` bit is set, pick the first set bit at or after `rr_ptr`, wrapping around.
  - Assert that requester's `req_ready` combinationally in the same cycle.
  - Latch a, b, op and the grant index.
  - Go to EXEC if the op is legal, otherwise go to RESP with result 0, flags 0 and err=1.
- EXEC (exactly one cycle):
  - Registered operands drive `alu_*`.
  - On the edge, capture `alu_result` and the flags into the response register, then go to RESP.
  - For SLT and SLTU, C and V are forced to 0.
- RESP:
  - `resp_valid[grant]` = 1.
  - Hold the response until `resp_ready[grant]`.
  - On that handshake, set `rr_ptr = (grant+1) mod NREQ` and go to IDLE.
  - `resp_ready` bits of non-granted requesters are ignored.
- `req_ready` is 0 in EXEC and RESP, so there is no overlap and at most one operation is in flight.
- A requester may drop `req_valid` before it is granted. Its request fields must stay stable only while `req_valid` is high within the grant cycle.
- Outside EXEC, `alu_srcA`, `alu_srcB` and `alu_control` hold their last values; no toggling is required.
- Legal ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Any other 5-bit code is illegal.

## Timing
- An accept handshake in cycle T gives `resp_valid` high from cycle T+2 (legal op) or T+1 (illegal op).
- Minimum spacing between accepts is 3 cycles with `resp_ready` tied high.
- Reset values:
  - State IDLE, `rr_ptr` = 0.
  - `req_ready`, `resp_valid`, `resp_err` = 0.
  - `resp_result` = 0, `resp_flags` = 0.
  - `alu_srcA`, `alu_srcB` = 0; `alu_control` = ADD code.
- Reset asserted in EXEC or RESP discards the in-flight operation. No response is delivered and the pointer returns to 0.
- Simultaneous requests are resolved by `rr_ptr`. With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- A back-pressured response (`resp_ready` = 0) keeps `resp_result`, `resp_flags` and `resp_err` stable every cycle until the handshake.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (5-bit) with the existing ALU code values.
  - `alu_op_legal()` function.
  - Flag index constants `FLAG_Z` = 0, `FLAG_N` = 1, `FLAG_C` = 2, `FLAG_V` = 3.
  - `arb_state_e`.
- One sub-module, `rr_picker`: a combinational round-robin first-set-bit finder from (vector, pointer) to (found, index).
- The `alu` is instantiated by the parent, not inside this block.

## Test plan
- Single request: req0 ADD a=5, b=7 at T. Expect `req_ready[0]` at T, `resp_valid[0]` at T+2 with result 12 and flags 0000.
- Contention: req0 and req1 both valid after reset. Expect grants 0 then 1 then 0. `resp_valid[1]` must not rise before the req0 response handshake.
- Flags:
  - SUB a=3, b=3 gives result 0 with Z=1.
  - ADD 0x7FFFFFFF+1 gives 0x80000000 with N=1, V=1.
  - SLT 0xFFFFFFFF<1 gives 1 with C=V=0.
- Illegal op 5'h1F: `resp_valid` at T+1 with `resp_err` = 1 and result 0. `alu_control` is unchanged.
- Backpressure: hold `resp_ready[0]` low for 5 cycles. The response stays stable, `req_ready` stays 0 for req1, and req1 is accepted in the cycle after the handshake.
- Reset in EXEC: `rst_n` low for one cycle. No `resp_valid`, all outputs at reset values, and the next grant goes to requester 0.
